// File: rtl/rob_int.sv
// In-order integer reorder buffer: packed multi-lane allocation, out-of-order
// completion, in-order retirement of up to WAYS entries per cycle, full flush on recover.

module rob_int_chk #(
    parameter int WAYS     = 3,
    parameter int ROB_SIZE = 32,
    parameter int ROB_IDX  = 5
) (
    input logic                    clock,
    input logic                    reset,
    input logic                    i_recover,
    input logic [WAYS-1:0]         i_complete_valid,
    input logic [WAYS*ROB_IDX-1:0] i_complete_index,
    input logic [ROB_SIZE-1:0]     i_valid,
    input logic [ROB_IDX:0]        i_count
);

    // Completion must target a live entry; occupancy can never exceed capacity.
    always @(posedge clock) begin
        if (!reset && !i_recover) begin
            for (int j = 0; j < WAYS; j++) begin
                if (i_complete_valid[j]) begin
                    assert (i_valid[i_complete_index[j*ROB_IDX +: ROB_IDX]]);
                end
            end
            assert (i_count <= (ROB_IDX+1)'(ROB_SIZE));
        end
    end

endmodule

module rob_int #(
    parameter int WAYS     = 3,
    parameter int ROB_SIZE = 32,
    parameter int ROB_IDX  = 5,
    parameter int ARF_IDX  = 5,
    parameter int PRF_IDX  = 6
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_recover,
    input  logic [WAYS-1:0]         i_in_valid,
    input  logic [WAYS-1:0]         i_in_dst_valid,
    input  logic [WAYS*ARF_IDX-1:0] i_in_arf_dst,
    input  logic [WAYS*PRF_IDX-1:0] i_in_prf_dst,
    input  logic [WAYS*PRF_IDX-1:0] i_in_prf_old,
    output logic                    o_in_ready,
    output logic [WAYS*ROB_IDX-1:0] o_alloc_index,
    input  logic [WAYS-1:0]         i_complete_valid,
    input  logic [WAYS*ROB_IDX-1:0] i_complete_index,
    output logic [WAYS-1:0]         o_commit_valid,
    output logic [WAYS-1:0]         o_commit_dst_valid,
    output logic [WAYS*ARF_IDX-1:0] o_commit_arf_dst,
    output logic [WAYS*PRF_IDX-1:0] o_commit_prf_dst,
    output logic [WAYS*PRF_IDX-1:0] o_commit_prf_old,
    output logic                    o_empty,
    output logic                    o_full
);

    logic [ROB_IDX-1:0] r_head;
    logic [ROB_IDX-1:0] r_tail;
    logic [ROB_IDX:0]   r_count;
    logic [ROB_SIZE-1:0] r_valid;
    logic [ROB_SIZE-1:0] r_complete;
    logic [ROB_SIZE-1:0] r_dst_valid;
    logic [ARF_IDX-1:0] r_arf     [ROB_SIZE];
    logic [PRF_IDX-1:0] r_prf     [ROB_SIZE];
    logic [PRF_IDX-1:0] r_prf_old [ROB_SIZE];
    logic               r_in_ready;
    logic               r_empty;
    logic               r_full;

    logic [ROB_IDX-1:0] w_alloc_idx  [WAYS];
    logic [ROB_IDX-1:0] w_commit_idx [WAYS];
    logic [ROB_IDX:0]   w_n_alloc;
    logic [ROB_IDX:0]   w_n_commit;
    logic [ROB_IDX:0]   w_count_next;
    logic [WAYS-1:0]    w_commit_valid;
    logic               w_alloc_fire;
    logic               w_chain;

    // Pack valid lanes onto consecutive slots starting at the tail.
    always_comb begin
        w_n_alloc = '0;
        for (int i = 0; i < WAYS; i++) begin
            w_alloc_idx[i] = r_tail + w_n_alloc[ROB_IDX-1:0];
            w_n_alloc      = w_n_alloc + {{ROB_IDX{1'b0}}, i_in_valid[i]};
        end
        w_alloc_fire = r_in_ready && (|i_in_valid) && !i_recover;
    end

    // Retire the longest run of completed entries from the head; recover suppresses it.
    always_comb begin
        w_chain    = !i_recover;
        w_n_commit = '0;
        for (int j = 0; j < WAYS; j++) begin
            w_commit_idx[j]   = r_head + ROB_IDX'(j);
            w_chain           = w_chain && r_valid[w_commit_idx[j]] && r_complete[w_commit_idx[j]];
            w_commit_valid[j] = w_chain;
            w_n_commit        = w_n_commit + {{ROB_IDX{1'b0}}, w_chain};
        end
    end

    // Occupancy after this cycle's allocation and retirement.
    always_comb begin
        if (w_alloc_fire) begin
            w_count_next = r_count + w_n_alloc - w_n_commit;
        end else begin
            w_count_next = r_count - w_n_commit;
        end
    end

    // Drive the per-lane output buses from the slot indices and head entries.
    always_comb begin
        o_alloc_index      = '0;
        o_commit_dst_valid = '0;
        o_commit_arf_dst   = '0;
        o_commit_prf_dst   = '0;
        o_commit_prf_old   = '0;
        for (int j = 0; j < WAYS; j++) begin
            o_alloc_index[j*ROB_IDX +: ROB_IDX]    = w_alloc_idx[j];
            o_commit_dst_valid[j]                  = w_commit_valid[j] && r_dst_valid[w_commit_idx[j]];
            o_commit_arf_dst[j*ARF_IDX +: ARF_IDX] = r_arf[w_commit_idx[j]];
            o_commit_prf_dst[j*PRF_IDX +: PRF_IDX] = r_prf[w_commit_idx[j]];
            o_commit_prf_old[j*PRF_IDX +: PRF_IDX] = r_prf_old[w_commit_idx[j]];
        end
    end

    assign o_commit_valid = w_commit_valid;
    assign o_in_ready     = r_in_ready;
    assign o_empty        = r_empty;
    assign o_full         = r_full;

    // Control state; later assignments win so a retired slot ends cleared.
    always_ff @(posedge clock) begin
        if (reset || i_recover) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_valid    <= '0;
            r_complete <= '0;
            r_in_ready <= 1'b1;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
        end else begin
            for (int j = 0; j < WAYS; j++) begin
                if (i_complete_valid[j] && r_valid[i_complete_index[j*ROB_IDX +: ROB_IDX]]) begin
                    r_complete[i_complete_index[j*ROB_IDX +: ROB_IDX]] <= 1'b1;
                end
            end
            for (int j = 0; j < WAYS; j++) begin
                if (w_commit_valid[j]) begin
                    r_valid[w_commit_idx[j]]    <= 1'b0;
                    r_complete[w_commit_idx[j]] <= 1'b0;
                end
            end
            if (w_alloc_fire) begin
                for (int i = 0; i < WAYS; i++) begin
                    if (i_in_valid[i]) begin
                        r_valid[w_alloc_idx[i]]    <= 1'b1;
                        r_complete[w_alloc_idx[i]] <= 1'b0;
                    end
                end
                r_tail <= r_tail + w_n_alloc[ROB_IDX-1:0];
            end
            r_head     <= r_head + w_n_commit[ROB_IDX-1:0];
            r_count    <= w_count_next;
            r_in_ready <= (w_count_next <= (ROB_IDX+1)'(ROB_SIZE - WAYS));
            r_empty    <= (w_count_next == '0);
            r_full     <= (w_count_next == (ROB_IDX+1)'(ROB_SIZE));
        end
    end

    // Payload capture; not reset because consumers only read it behind valid.
    always_ff @(posedge clock) begin
        if (!reset && w_alloc_fire) begin
            for (int i = 0; i < WAYS; i++) begin
                if (i_in_valid[i]) begin
                    r_dst_valid[w_alloc_idx[i]] <= i_in_dst_valid[i];
                    r_arf[w_alloc_idx[i]]       <= i_in_arf_dst[i*ARF_IDX +: ARF_IDX];
                    r_prf[w_alloc_idx[i]]       <= i_in_prf_dst[i*PRF_IDX +: PRF_IDX];
                    r_prf_old[w_alloc_idx[i]]   <= i_in_prf_old[i*PRF_IDX +: PRF_IDX];
                end
            end
        end
    end

    rob_int_chk #(
        .WAYS     (WAYS),
        .ROB_SIZE (ROB_SIZE),
        .ROB_IDX  (ROB_IDX)
    ) u_chk (
        .clock            (clock),
        .reset            (reset),
        .i_recover        (i_recover),
        .i_complete_valid (i_complete_valid),
        .i_complete_index (i_complete_index),
        .i_valid          (r_valid),
        .i_count          (r_count)
    );

endmodule

// File: tb/tb_rob_int.sv
// Directed bench for rob_int: allocation packing, completion/commit, capacity,
// wrap-around, recover and mid-operation reset, all against hand-computed values.

module tb_rob_int;

    logic        clock = 1'b0;
    logic        reset;
    logic        recover;
    logic [2:0]  in_valid;
    logic [2:0]  in_dst_valid;
    logic [14:0] in_arf_dst;
    logic [17:0] in_prf_dst;
    logic [17:0] in_prf_old;
    logic        in_ready;
    logic [14:0] alloc_index;
    logic [2:0]  complete_valid;
    logic [14:0] complete_index;
    logic [2:0]  commit_valid;
    logic [2:0]  commit_dst_valid;
    logic [14:0] commit_arf_dst;
    logic [17:0] commit_prf_dst;
    logic [17:0] commit_prf_old;
    logic        empty;
    logic        full;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    rob_int dut (
        .clock              (clock),
        .reset              (reset),
        .i_recover          (recover),
        .i_in_valid         (in_valid),
        .i_in_dst_valid     (in_dst_valid),
        .i_in_arf_dst       (in_arf_dst),
        .i_in_prf_dst       (in_prf_dst),
        .i_in_prf_old       (in_prf_old),
        .o_in_ready         (in_ready),
        .o_alloc_index      (alloc_index),
        .i_complete_valid   (complete_valid),
        .i_complete_index   (complete_index),
        .o_commit_valid     (commit_valid),
        .o_commit_dst_valid (commit_dst_valid),
        .o_commit_arf_dst   (commit_arf_dst),
        .o_commit_prf_dst   (commit_prf_dst),
        .o_commit_prf_old   (commit_prf_old),
        .o_empty            (empty),
        .o_full             (full)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        recover        = 1'b0;
        in_valid       = 3'b000;
        in_dst_valid   = 3'b000;
        complete_valid = 3'b000;
    endtask

    task automatic set_lane(input int i, input logic v, input logic dv,
                            input logic [4:0] arf, input logic [5:0] prf, input logic [5:0] old);
        in_valid[i]            = v;
        in_dst_valid[i]        = dv;
        in_arf_dst[i*5 +: 5]   = arf;
        in_prf_dst[i*6 +: 6]   = prf;
        in_prf_old[i*6 +: 6]   = old;
    endtask

    task automatic comp(input int j, input logic [4:0] idx);
        complete_valid[j]        = 1'b1;
        complete_index[j*5 +: 5] = idx;
    endtask

    function automatic logic [4:0] ai(input int i);
        return alloc_index[i*5 +: 5];
    endfunction

    function automatic logic [5:0] c_old(input int j);
        return commit_prf_old[j*6 +: 6];
    endfunction

    function automatic logic [5:0] c_prf(input int j);
        return commit_prf_dst[j*6 +: 6];
    endfunction

    function automatic logic [4:0] c_arf(input int j);
        return commit_arf_dst[j*5 +: 5];
    endfunction

    initial begin
        reset          = 1'b1;
        idle();
        in_arf_dst     = 15'd0;
        in_prf_dst     = 18'd0;
        in_prf_old     = 18'd0;
        complete_index = 15'd0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_commit_valid", commit_valid, 0);

        // Three-lane allocation from an empty buffer.
        set_lane(0, 1'b1, 1'b1, 5'd1, 6'd33, 6'd1);
        set_lane(1, 1'b1, 1'b1, 5'd2, 6'd34, 6'd2);
        set_lane(2, 1'b1, 1'b1, 5'd3, 6'd35, 6'd3);
        #1;
        chk("alloc3_index", alloc_index, {5'd2, 5'd1, 5'd0});
        tick();
        idle();
        #1;
        chk("alloc3_empty", empty, 0);
        chk("alloc3_in_ready", in_ready, 1);
        chk("alloc3_tail", ai(0), 3);

        // Sparse lanes 0 and 2; lane 2 has no destination.
        set_lane(0, 1'b1, 1'b1, 5'd4, 6'd36, 6'd4);
        set_lane(1, 1'b0, 1'b0, 5'd0, 6'd0, 6'd0);
        set_lane(2, 1'b1, 1'b0, 5'd5, 6'd37, 6'd5);
        #1;
        chk("sparse_lane0", ai(0), 3);
        chk("sparse_lane2", ai(2), 4);
        tick();
        idle();
        #1;
        chk("sparse_tail", ai(0), 5);

        // Complete 1 and 0 out of order; no same-cycle bypass.
        comp(0, 5'd1);
        comp(1, 5'd0);
        #1;
        chk("no_bypass", commit_valid, 0);
        tick();
        idle();
        #1;
        chk("c01_valid", commit_valid, 3'b011);
        chk("c01_old0", c_old(0), 1);
        chk("c01_old1", c_old(1), 2);
        chk("c01_arf0", c_arf(0), 1);
        chk("c01_prf1", c_prf(1), 34);
        tick();
        chk("c01_after", commit_valid, 0);
        comp(2, 5'd2);
        tick();
        idle();
        #1;
        chk("c2_valid", commit_valid, 3'b001);
        chk("c2_old0", c_old(0), 3);
        chk("c2_prf0", c_prf(0), 35);
        tick();

        // Duplicate completion indices in one cycle.
        comp(0, 5'd4);
        comp(1, 5'd3);
        comp(2, 5'd3);
        tick();
        idle();
        #1;
        chk("c34_valid", commit_valid, 3'b011);
        chk("c34_dst_valid", commit_dst_valid, 3'b001);
        chk("c34_old0", c_old(0), 4);
        chk("c34_arf1", c_arf(1), 5);
        tick();
        chk("drained_empty", empty, 1);

        // Fill to 30 entries: entry n lands in slot (5+n)%32 with old = n.
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 3; i++) begin
                set_lane(i, 1'b1, 1'b1, 5'(k*3+i), 6'(k*3+i+32), 6'(k*3+i));
            end
            tick();
        end
        idle();
        #1;
        chk("fill_in_ready", in_ready, 0);
        chk("fill_full", full, 0);
        chk("fill_tail", ai(0), 3);
        for (int i = 0; i < 3; i++) begin
            set_lane(i, 1'b1, 1'b1, 5'd31, 6'd63, 6'd63);
        end
        tick();
        idle();
        #1;
        chk("ignored_alloc_tail", ai(0), 3);
        chk("ignored_alloc_ready", in_ready, 0);
        comp(0, 5'd5);
        comp(1, 5'd6);
        comp(2, 5'd7);
        tick();
        idle();
        #1;
        chk("c567_valid", commit_valid, 3'b111);
        chk("c567_old0", c_old(0), 0);
        chk("c567_old2", c_old(2), 2);
        chk("no_credit_ready", in_ready, 0);
        tick();
        chk("credit_ready", in_ready, 1);

        // Retire slots 8..29 so the head sits at 30.
        for (int s = 8; s < 30; s += 3) begin
            for (int j = 0; j < 3; j++) begin
                if (s + j < 30) begin
                    comp(j, 5'(s + j));
                end
            end
            tick();
            idle();
        end
        tick();
        tick();
        chk("wrap_idle", commit_valid, 0);
        comp(0, 5'd30);
        comp(1, 5'd31);
        comp(2, 5'd0);
        tick();
        idle();
        #1;
        chk("wrap_valid", commit_valid, 3'b111);
        chk("wrap_old0", c_old(0), 25);
        chk("wrap_old1", c_old(1), 26);
        chk("wrap_old2", c_old(2), 27);
        chk("wrap_arf2", c_arf(2), 27);
        tick();
        chk("wrap_after", commit_valid, 0);
        comp(0, 5'd1);
        tick();
        idle();
        #1;
        chk("head1_valid", commit_valid, 3'b001);
        chk("head1_old0", c_old(0), 28);
        tick();

        // Recover with 10 entries, two commit-eligible, completions and allocation pending.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 3; i++) begin
                set_lane(i, 1'b1, 1'b1, 5'(k*3+i), 6'(k*3+i), 6'(k*3+i+40));
            end
            tick();
        end
        idle();
        comp(0, 5'd2);
        comp(1, 5'd3);
        tick();
        idle();
        #1;
        chk("pre_recover_valid", commit_valid, 3'b011);
        recover = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_lane(i, 1'b1, 1'b1, 5'd7, 6'd7, 6'd7);
        end
        comp(0, 5'd4);
        comp(1, 5'd5);
        #1;
        chk("recover_commit_valid", commit_valid, 0);
        tick();
        idle();
        #1;
        chk("rec_empty", empty, 1);
        chk("rec_in_ready", in_ready, 1);
        chk("rec_tail", ai(0), 0);
        chk("rec_commit_valid", commit_valid, 0);
        set_lane(0, 1'b1, 1'b1, 5'd9, 6'd50, 6'd7);
        tick();
        idle();
        comp(0, 5'd0);
        tick();
        idle();
        #1;
        chk("rec_head_valid", commit_valid, 3'b001);
        chk("rec_head_old", c_old(0), 7);
        tick();
        chk("rec_drain_empty", empty, 1);

        // Reach exactly full: 29 entries keeps in_ready, 32 sets full.
        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < 3; i++) begin
                set_lane(i, 1'b1, 1'b1, 5'd1, 6'd1, 6'd1);
            end
            tick();
        end
        set_lane(2, 1'b0, 1'b0, 5'd0, 6'd0, 6'd0);
        tick();
        idle();
        #1;
        chk("cnt29_in_ready", in_ready, 1);
        chk("cnt29_full", full, 0);
        for (int i = 0; i < 3; i++) begin
            set_lane(i, 1'b1, 1'b1, 5'd2, 6'd2, 6'd2);
        end
        tick();
        idle();
        #1;
        chk("cnt32_full", full, 1);
        chk("cnt32_in_ready", in_ready, 0);

        // Reset mid-operation.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_full", full, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_commit", commit_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rob_int.md
Name: rob_int

Overview:
- In-order reorder buffer for the integer pipeline, directly downstream of the rename/RAT stage.
- Accepts up to WAYS renamed instructions per cycle and records for each its architectural destination, new PRF destination and previous PRF mapping.
- Tracks completion and retires up to WAYS oldest completed entries per cycle.
- Retired old-PRF indices go to the free list; retired (arf, prf) pairs go to the retirement map.

Parameters:
WAYS, 3, rename/commit width (matches PRF_INT_WAYS)
ROB_SIZE, 32, entry count; power of two, >= 2*WAYS
ROB_IDX, 5, log2(ROB_SIZE)
ARF_IDX, 5, architectural register index width
PRF_IDX, 6, physical register index width

Ports:
clock  input  1  clock, rising edge
reset  input  1  synchronous, active-high
recover  input  1  flush all entries (branch mispredict/exception)
in_valid  input  WAYS  lane carries a renamed instruction
in_dst_valid  input  WAYS  lane writes a destination register
in_arf_dst  input  WAYS*ARF_IDX  architectural destination
in_prf_dst  input  WAYS*PRF_IDX  newly allocated PRF
in_prf_old  input  WAYS*PRF_IDX  PRF previously mapped to in_arf_dst
in_ready  output  1  free entries >= WAYS
alloc_index  output  WAYS*ROB_IDX  ROB slot assigned to each lane (combinational)
complete_valid  input  WAYS  completion report from a writeback port
complete_index  input  WAYS*ROB_IDX  ROB slot being completed
commit_valid  output  WAYS  lane retires this cycle
commit_dst_valid  output  WAYS  retiring instruction had a destination
commit_arf_dst  output  WAYS*ARF_IDX  retiring arch destination
commit_prf_dst  output  WAYS*PRF_IDX  retiring PRF destination
commit_prf_old  output  WAYS*PRF_IDX  PRF to return to free list
empty  output  1  count == 0
full  output  1  count == ROB_SIZE

Behaviour:
- State: head, tail (ROB_IDX bits, wrap modulo ROB_SIZE); count (ROB_IDX+1 bits); per entry: valid, complete, dst_valid, arf, prf, prf_old.
- Reset (sync, high):
  - head = tail = count = 0; all valid/complete bits = 0.
  - Outputs: in_ready = 1, empty = 1, full = 0, commit_valid = 0.
  - Payload fields are not reset.
- Allocation fires on a clock edge when in_ready && |in_valid && !recover.
  - Valid lanes are packed in lane order: lane i gets tail + popcount(in_valid[i-1:0]).
  - alloc_index is driven for every lane; only valid lanes' values are meaningful.
  - tail advances by popcount(in_valid); new entries are valid = 1, complete = 0.
  - When in_ready = 0, inputs are ignored. Upstream holds its inputs; there is no partial accept.
- Completion: for each complete_valid lane, entry[complete_index].complete <= 1 at the edge.
  - Completion of an invalid entry is ignored and flagged by an assertion.
  - Duplicate indices in one cycle are legal.
  - Completion takes effect at the edge. The entry is commit-eligible from the next cycle; there is no same-cycle bypass.
- Commit (combinational from registered state):
  - Lane j valid iff entries head..head+j are all valid && complete; stops at the first non-completed entry.
  - Payload is taken from entry head+j.
  - At the edge, head advances by the commit count and committed entries are cleared (valid = 0, complete = 0).
- Simultaneous alloc + commit in one cycle:
  - count_next = count + n_alloc - n_commit.
  - in_ready uses the registered count only (no same-cycle credit from commit).
- Wrap-around: indices and packed allocations roll from ROB_SIZE-1 to 0 transparently. Commit across the wrap point is legal.
- Recover:
  - While recover = 1, commit_valid is forced to 0 in that cycle.
  - At the edge: head = tail = count = 0 and all valid/complete bits are cleared.
  - Allocation and completion in the same cycle are discarded.
  - Recover with count = 0 is a no-op.
- Reset mid-operation behaves as recover plus full reinitialisation.
- in_dst_valid = 0 entries retire with commit_dst_valid = 0. Consumers must ignore their arf/prf fields.

Test Plan:
- After reset, allocate lanes {1,1,1}, arf {1,2,3}, prf {33,34,35}, old {1,2,3} -> alloc_index {0,1,2}, count = 3, empty = 0.
- Sparse lanes in_valid = 3'b101 at tail = 3 -> lane0 idx 3, lane2 idx 4, lane1 unused, tail = 5.
- Complete idx 1, 0 in cycle k -> cycle k+1 commit_valid = 3'b011 with old {1,2}, head = 2. Then complete idx 2 -> idx 2 retires the next cycle.
- Fill to 30 entries -> in_ready = 0 and allocation is ignored. Commit 3 -> count = 27, in_ready = 1 the next cycle.
- Wrap: head = 30, entries 30, 31, 0 complete -> single-cycle commit of all three, head = 1.
- Recover asserted with 10 entries, 2 completing and an allocation pending -> commit_valid = 0 that cycle; next cycle empty = 1, head = tail = 0, in_ready = 1.
